// File: rtl/sa_pkg.sv
// sa_pkg: shared widths, types and helpers for the simple-adder result path.
//   SA_BUS_WIDTH : width of one adder result word
//   SA_RB_DEPTH  : default result-buffer depth (power of two, >= 2)
//   sa_word_t    : one adder result word
//   sa_rb_stat_t : 16-bit statistics counter
package sa_pkg;
  localparam int SA_BUS_WIDTH = 4;
  localparam int SA_RB_DEPTH  = 8;

  typedef logic [SA_BUS_WIDTH-1:0] sa_word_t;
  typedef logic [15:0]             sa_rb_stat_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic sa_rb_stat_t sa_sat_inc(input sa_rb_stat_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sa_rb_mem.sv
// sa_rb_mem: DEPTH x WIDTH storage for the result buffer.
// Synchronous write, asynchronous (combinational) read so the head word is
// visible as soon as the read pointer moves. Contents are not reset.
// Ports:
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : data stored at raddr_i
module sa_rb_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sa_result_buffer.sv
// sa_result_buffer: captures adder results (sig_out qualified by sig_en_o)
// into a first-word-fall-through FIFO and drains them over valid/ready.
// A push arriving while full and not popping is dropped and sets the sticky
// overflow flag (set beats ovf_clr in the same cycle).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   sig_out, sig_en_o   : adder result and its valid strobe (push request)
//   m_data, m_valid     : head word and its valid (FIFO not empty)
//   m_ready             : consumer accepts m_data this cycle
//   count, full, empty  : occupancy and derived flags
//   overflow, ovf_clr   : sticky drop flag and its clear
//   accept_cnt, drop_cnt: saturating push/drop counters (only when the
//                         SA_RB_STATS_EN macro is defined)
module sa_result_buffer
  import sa_pkg::*;
#(
  parameter int BUS_WIDTH = SA_BUS_WIDTH,
  parameter int DEPTH     = SA_RB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_WIDTH-1:0]         sig_out,
  input  logic                         sig_en_o,
  output logic [BUS_WIDTH-1:0]         m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  input  logic                         ovf_clr
`ifdef SA_RB_STATS_EN
  ,
  output sa_rb_stat_t                  accept_cnt,
  output sa_rb_stat_t                  drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 push, pop, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign m_valid = !empty;
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = sig_en_o & (!full | pop);
  assign drop    = sig_en_o & full & !pop;

  sa_rb_mem #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (sig_out),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Memory is not reset, so mask the head word to zero while empty.
  assign m_data   = m_valid ? rd_data : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    // Power-of-two depth: pointers wrap naturally.
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SA_RB_STATS_EN
  sa_rb_stat_t accept_cnt_q, accept_cnt_d;
  sa_rb_stat_t drop_cnt_q,   drop_cnt_d;

  always_comb begin
    accept_cnt_d = push ? sa_sat_inc(accept_cnt_q) : accept_cnt_q;
    drop_cnt_d   = drop ? sa_sat_inc(drop_cnt_q)   : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign accept_cnt = accept_cnt_q;
  assign drop_cnt   = drop_cnt_q;
`endif
endmodule

// File: tb/tb_sa_result_buffer.sv
// tb_sa_result_buffer: table-driven directed vectors for sa_result_buffer plus
// a hand-written continuous push/pop sequence across pointer wrap.
// Define SA_RB_STATS_EN to also check accept_cnt/drop_cnt.
module tb_sa_result_buffer;
  import sa_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sig_out = '0;
  logic       sig_en_o = 1'b0;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [3:0] count;
  logic       full, empty, overflow;
  logic       ovf_clr = 1'b0;
`ifdef SA_RB_STATS_EN
  sa_rb_stat_t accept_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  sa_result_buffer #(.BUS_WIDTH(4), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_out  (sig_out),
    .sig_en_o (sig_en_o),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`ifdef SA_RB_STATS_EN
    ,
    .accept_cnt (accept_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  typedef struct {
    logic       rst, en;
    logic [3:0] din;
    logic       rdy, clr;
    logic       v;
    logic [3:0] d;
    logic [3:0] c;
    logic       f, e, o;
    int         acc, drp;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];
  int   nv = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic en, input logic [3:0] din,
                     input logic rdy, input logic clr, input logic v,
                     input logic [3:0] d, input logic [3:0] c, input logic f,
                     input logic e, input logic o, input int acc, input int drp);
    tbl[nv] = '{r, en, din, rdy, clr, v, d, c, f, e, o, acc, drp};
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  logic [3:0] q [$];

  initial begin
    // Test 1: reset, push 3,5,9 stalled, then drain.
    add(1,0,0,0,0, 0,0,0,0,1,0, 0,0);
    add(0,1,3,0,0, 1,3,1,0,0,0, 1,0);
    add(0,1,5,0,0, 1,3,2,0,0,0, 2,0);
    add(0,1,9,0,0, 1,3,3,0,0,0, 3,0);
    add(0,0,0,0,0, 1,3,3,0,0,0, 3,0);   // stall: head stays put
    add(0,0,0,1,0, 1,5,2,0,0,0, 3,0);
    add(0,0,0,1,0, 1,9,1,0,0,0, 3,0);
    add(0,0,0,1,0, 0,0,0,0,1,0, 3,0);
    add(0,0,0,1,0, 0,0,0,0,1,0, 3,0);   // empty & ready: no pop
    // Test 2: fill 0..7, then a 9th push is dropped.
    for (int k = 0; k < 8; k++)
      add(0,1,4'(k),0,0, 1,0,4'(k+1),(k==7),0,0, 4+k,0);
    add(0,1,4'hF,0,0, 1,0,8,1,0,1, 11,1);
    // Test 5a: clear alone.
    add(0,0,0,0,1, 1,0,8,1,0,0, 11,1);
    // Test 3: full, push A with pop.
    add(0,1,4'hA,1,0, 1,1,8,1,0,0, 12,1);
    // Test 5b: clear with a dropped push -> set wins; then clear.
    add(0,1,4'hF,0,1, 1,1,8,1,0,1, 12,2);
    add(0,0,0,0,1, 1,1,8,1,0,0, 12,2);
    // Drain: 1..7 then A, the dropped F never appears.
    for (int k = 0; k < 6; k++)
      add(0,0,0,1,0, 1,4'(k+2),4'(7-k),0,0,0, 12,2);
    add(0,0,0,1,0, 1,4'hA,1,0,0,0, 12,2);
    add(0,0,0,1,0, 0,0,0,0,1,0, 12,2);
    // Test 6: five words, then reset with a push in the reset cycle.
    for (int k = 0; k < 5; k++)
      add(0,1,4'(k+1),0,0, 1,1,4'(k+1),0,0,0, 13+k,2);
    add(1,1,7,0,0, 0,0,0,0,1,0, 0,0);
    add(0,0,0,0,0, 0,0,0,0,1,0, 0,0);

    for (int i = 0; i < nv; i++) begin
      rst = tbl[i].rst; sig_en_o = tbl[i].en; sig_out = tbl[i].din;
      m_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
      @(posedge clk); #1;
      $display("vec %0d: valid=%0b data=%0h count=%0d full=%0b empty=%0b ovf=%0b",
               i, m_valid, m_data, count, full, empty, overflow);
      chk("m_valid",  i, int'(m_valid),  int'(tbl[i].v));
      chk("m_data",   i, int'(m_data),   int'(tbl[i].d));
      chk("count",    i, int'(count),    int'(tbl[i].c));
      chk("full",     i, int'(full),     int'(tbl[i].f));
      chk("empty",    i, int'(empty),    int'(tbl[i].e));
      chk("overflow", i, int'(overflow), int'(tbl[i].o));
`ifdef SA_RB_STATS_EN
      chk("accept_cnt", i, int'(accept_cnt), tbl[i].acc);
      chk("drop_cnt",   i, int'(drop_cnt),   tbl[i].drp);
`endif
    end

    // Test 4: one word preloaded, then 20 cycles of push+pop across wrap.
    rst = 0; ovf_clr = 0;
    sig_en_o = 1; sig_out = 4'hC; m_ready = 0;
    @(posedge clk); #1;
    q.push_back(4'hC);
    chk("wrap_preload_count", 100, int'(count), 1);
    for (int i = 0; i < 20; i++) begin
      sig_en_o = 1; sig_out = 4'(i % 16); m_ready = 1;
      chk("wrap_head", 101 + i, int'(m_data), int'(q[0]));
      @(posedge clk); #1;
      void'(q.pop_front());
      q.push_back(4'(i % 16));
      $display("wrap %0d: pushed=%0h head=%0h count=%0d", i, i % 16, m_data, count);
      chk("wrap_count", 101 + i, int'(count), 1);
    end
    sig_en_o = 0; m_ready = 1;
    chk("wrap_last", 130, int'(m_data), int'(q[0]));
    @(posedge clk); #1;
    chk("wrap_empty", 131, int'(empty), 1);
    m_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
